// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and geometry helpers for the burst SRAM core.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, PRECH, ACCESS, RESP} state_t;
  function automatic int addr_w(int row_bits, int col_bits);
    return row_bits + col_bits;
  endfunction
  function automatic int num_rows(int row_bits);
    return 1 << row_bits;
  endfunction
  function automatic int words_per_row(int col_bits);
    return 1 << col_bits;
  endfunction
  function automatic int num_bitlines(int word_size, int col_bits);
    return word_size * (1 << col_bits);
  endfunction
endpackage

// File: rtl/sram_array_model.sv
// sram_array_model: behavioural bit-cell array with per-bit masked write and registered read.
module sram_array_model
  import sram_pkg::*;
#(
  parameter int WORD_SIZE = 4,
  parameter int ROW_BITS  = 6,
  parameter int COL_BITS  = 4
) (
  input  logic                 clk,
  input  logic [ROW_BITS-1:0]  row,
  input  logic [COL_BITS-1:0]  col,
  input  logic                 we,
  input  logic                 re,
  input  logic [WORD_SIZE-1:0] wmask,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);
  localparam int NUM_ROWS = num_rows(ROW_BITS);
  localparam int WPR = words_per_row(COL_BITS);
  logic [WORD_SIZE-1:0] mem [NUM_ROWS][WPR];
  // Contents are deliberately not reset, matching a real bit-cell array.
  always_ff @(posedge clk) begin
    if (we) mem[row][col] <= (mem[row][col] & ~wmask) | (wdata & wmask);
    if (re) rdata <= mem[row][col];
  end
endmodule

// File: rtl/sram_core_burst.sv
// sram_core_burst: valid/ready SRAM front end running precharge/access beats over auto-incrementing bursts.
module sram_core_burst
  import sram_pkg::*;
#(
  parameter int WORD_SIZE  = 4,
  parameter int ROW_BITS   = 6,
  parameter int COL_BITS   = 4,
  parameter int BURST_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]         req_wdata,
  input  logic [WORD_SIZE-1:0]         req_wmask,
  input  logic [BURST_BITS-1:0]        req_burst,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_SIZE-1:0]         rsp_data,
  output logic                         rsp_last,
  output logic                         wr_done,
  output logic                         precharge_en,
  output logic                         busy
);
  state_t                 state;
  logic                   we_q;
  logic [ROW_BITS-1:0]    row;
  logic [COL_BITS-1:0]    col;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   wmask_q;
  logic [WORD_SIZE-1:0]   rdata;
  logic [BURST_BITS-1:0]  beats_left;
  logic                   last;
  assign last      = beats_left == '0;
  assign req_ready = rst_n && state == IDLE;
  assign busy      = state != IDLE;
  // The array read register only loads in ACCESS, so it is stable for all of RESP.
  assign rsp_data  = rsp_valid ? rdata : '0;
  sram_array_model #(
    .WORD_SIZE(WORD_SIZE),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_array (
    .clk  (clk),
    .row  (row),
    .col  (col),
    .we   (state == ACCESS && we_q),
    .re   (state == ACCESS && !we_q),
    .wmask(wmask_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      row          <= '0;
      col          <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      beats_left   <= '0;
      rsp_valid    <= 1'b0;
      rsp_last     <= 1'b0;
      wr_done      <= 1'b0;
      precharge_en <= 1'b0;
    end else begin
      wr_done      <= 1'b0;
      precharge_en <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q         <= req_we;
          row          <= req_addr[ROW_BITS+COL_BITS-1:COL_BITS];
          col          <= req_addr[COL_BITS-1:0];
          wdata_q      <= req_wdata;
          wmask_q      <= req_wmask;
          beats_left   <= req_burst;
          precharge_en <= 1'b1;
          state        <= PRECH;
        end
        PRECH: state <= ACCESS;
        ACCESS: if (!we_q) begin
          rsp_valid <= 1'b1;
          rsp_last  <= last;
          state     <= RESP;
        end else if (last) begin
          wr_done <= 1'b1;
          state   <= IDLE;
        end else begin
          beats_left   <= beats_left - 1'b1;
          col          <= col + 1'b1;
          precharge_en <= 1'b1;
          state        <= PRECH;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_last  <= 1'b0;
          if (last) state <= IDLE;
          else begin
            beats_left   <= beats_left - 1'b1;
            col          <= col + 1'b1;
            precharge_en <= 1'b1;
            state        <= PRECH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_core_burst.sv
// tb_sram_core_burst: directed and randomized bursts checked every cycle against a transaction-level model.
module tb_sram_core_burst;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [9:0] req_addr = '0;
  logic [3:0] req_wdata = '0, req_wmask = '0;
  logic [1:0] req_burst = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_last, wr_done, precharge_en, busy;
  logic [3:0] rsp_data;

  sram_core_burst dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_burst(req_burst), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .wr_done(wr_done),
    .precharge_en(precharge_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit rnd_rdy = 1'b0;
  logic [3:0] rd_q[$];
  bit lasts[$];

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: memory with per-bit known flags; an operation is timed by cycles since accept/handshake.
  logic [3:0] mv [1024];
  logic [3:0] mk [1024];
  int m_mode = 0, m_t = 0, m_beat = 0, m_beats = 0;
  logic [9:0] m_addr = '0;
  logic [3:0] m_wd = '0, m_wm = '0, m_rd = '0, m_rk = '0;
  bit m_done = 1'b0;

  always @(negedge clk) begin
    bit e_ready, e_busy, e_pre, e_done, e_valid, e_last;
    logic [9:0] a;
    e_ready = 0; e_busy = 0; e_pre = 0; e_done = 0; e_valid = 0; e_last = 0;
    if (rst_n) begin
      e_ready = m_mode == 0;
      e_busy  = m_mode != 0;
      e_done  = m_mode == 0 && m_done;
      e_pre   = (m_mode == 1 && m_t % 2 == 1) || (m_mode == 2 && m_t == 1);
      e_valid = m_mode == 2 && m_t >= 3;
      e_last  = e_valid && m_beat == m_beats - 1;
    end
    chk("req_ready", int'(req_ready), int'(e_ready));
    chk("busy", int'(busy), int'(e_busy));
    chk("precharge_en", int'(precharge_en), int'(e_pre));
    chk("wr_done", int'(wr_done), int'(e_done));
    chk("rsp_valid", int'(rsp_valid), int'(e_valid));
    if (e_valid && rsp_valid) begin
      chk("rsp_last", int'(rsp_last), int'(e_last));
      chk("rsp_data", int'(rsp_data & m_rk), int'(m_rd & m_rk));
    end
    if (!rst_n) chk("rsp_data_rst", int'(rsp_data), 0);
    a = {m_addr[9:4], m_addr[3:0] + 4'(m_beat)};
    if (!rst_n) begin
      m_mode = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (req_valid) begin
          m_mode = req_we ? 1 : 2; m_t = 1; m_beat = 0; m_beats = int'(req_burst) + 1;
          m_addr = req_addr; m_wd = req_wdata; m_wm = req_wmask;
        end
      end else if (m_mode == 1) begin
        if (m_t % 2 == 0) begin
          mv[a] = (mv[a] & ~m_wm) | (m_wd & m_wm);
          mk[a] = mk[a] | m_wm;
          if (m_beat == m_beats - 1) begin m_mode = 0; m_done = 1; end
          else m_beat++;
        end
        m_t++;
      end else begin
        if (m_t == 2) begin m_rd = mv[a]; m_rk = mk[a]; end
        if (m_t >= 3 && rsp_ready) begin
          if (m_beat == m_beats - 1) m_mode = 0;
          else begin m_beat++; m_t = 1; end
        end else m_t++;
      end
    end
  end

  task automatic req(bit we, logic [9:0] a, logic [3:0] d, logic [3:0] m, logic [1:0] b);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m; req_burst = b;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
    req_we = 1'($urandom); req_addr = 10'($urandom); req_wdata = 4'($urandom);
    req_wmask = 4'($urandom); req_burst = 2'($urandom);
  endtask

  task automatic do_write(logic [9:0] a, logic [3:0] d, logic [3:0] m, logic [1:0] b, output int lat);
    req(1, a, d, m, b);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (wr_done) begin lat = n; break; end
    end
    if (lat == 0) chk("wr_timeout", 0, 1);
  endtask

  task automatic do_read(logic [9:0] a, logic [1:0] b, int stall_beat, output int lat);
    int beat = 0, stall = 0;
    bit done = 0;
    rd_q.delete(); lasts.delete();
    req(0, a, 4'h0, 4'h0, b);
    lat = 0;
    for (int n = 1; n < 300 && !done; n++) begin
      rsp_ready = (beat == stall_beat && stall < 5) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (rsp_valid && lat == 0) lat = n;
      if (rsp_valid) begin
        if (!rsp_ready) begin
          if (beat == stall_beat) stall++;
        end else begin
          rd_q.push_back(rsp_data); lasts.push_back(rsp_last); beat++;
          if (rsp_last) done = 1;
        end
      end
      @(posedge clk); #1;
    end
    if (!done) chk("rd_timeout", 0, 1);
    rsp_ready = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 1024; i++) begin mv[i] = '0; mk[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    do_write(10'h123, 4'hA, 4'hF, 2'd0, lat);
    chk("wr_latency", lat, 3);
    do_read(10'h123, 2'd0, -1, lat);
    chk("rd_latency", lat, 3);
    chk("rd_count", rd_q.size(), 1);
    chk("rd_123", int'(rd_q[0]), 'hA);
    chk("rd_123_last", int'(lasts[0]), 1);
    do_write(10'h123, 4'h5, 4'h3, 2'd0, lat);
    do_read(10'h123, 2'd0, -1, lat);
    chk("masked_rd", int'(rd_q[0]), 'h9);
    do_write(10'h042, 4'h2, 4'hF, 2'd0, lat);
    do_write(10'h04E, 4'h7, 4'hF, 2'd3, lat);
    chk("fill_latency", lat, 9);
    do_read(10'h04F, 2'd0, -1, lat);
    chk("fill_04F", int'(rd_q[0]), 'h7);
    do_read(10'h040, 2'd1, -1, lat);
    chk("fill_040", int'(rd_q[0]), 'h7);
    chk("fill_041", int'(rd_q[1]), 'h7);
    do_read(10'h042, 2'd0, -1, lat);
    chk("untouched_042", int'(rd_q[0]), 'h2);
    do_read(10'h04E, 2'd3, 1, lat);
    chk("burst_count", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_data", int'(rd_q[i]), 'h7);
      chk("burst_last", int'(lasts[i]), i == 3 ? 1 : 0);
    end
    do_write(10'h200, 4'h3, 4'hF, 2'd0, lat);
    req(1, 10'h200, 4'hC, 4'hF, 2'd0);
    rst_n = 0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_prech", int'(precharge_en), 0);
    chk("rst_ready", int'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    do_read(10'h200, 2'd0, -1, lat);
    chk("rst_kept_200", int'(rd_q[0]), 'h3);
    rnd_rdy = 1;
    for (int k = 0; k < 80; k++) begin
      logic [9:0] a;
      a = {4'b0, 2'($urandom_range(0, 1)), 4'($urandom)};
      if ($urandom_range(0, 1) == 1) do_write(a, 4'($urandom), 4'($urandom), 2'($urandom), lat);
      else do_read(a, 2'($urandom), -1, lat);
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
